// File: rtl/code_pack.sv
// Shared definitions for the 9-bit CPU fetch front end.
package code_pack;

    localparam int PC_W = 10;
    localparam int IW   = 9;

    localparam logic [IW-1:0] NOP_WORD = 9'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit boundary: instruction memory port, decoder hand-off and run control.
interface instr_fetch_if
    import code_pack::*;
();

    logic            start;
    logic            done;
    logic [PC_W-1:0] im_addr;
    logic [IW-1:0]   im_data;
    logic            stall;
    logic            br_take;
    logic [PC_W-1:0] br_off;
    logic            halt;
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;

    modport master (
        input  start, im_data, stall, br_take, br_off, halt,
        output done, im_addr, ir, ir_pc, ir_valid
    );

    modport slave (
        output start, im_data, stall, br_take, br_off, halt,
        input  done, im_addr, ir, ir_pc, ir_valid
    );

endinterface

// File: rtl/instr_fetch.sv
// Fetch front end: program counter, IF/ID holding register, relative-jump redirect
// and start/done run control.
module instr_fetch
    import code_pack::*;
(
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            ir_q       <= NOP_WORD;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            done_q     <= done_d;
        end
    end

    // Priority order: start, halt, stall, taken branch, sequential fetch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        done_d     = done_q;

        if (bus.start) begin
            state_d    = IDLE;
            fetch_pc_d = '0;
            ir_valid_d = 1'b0;
            done_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.halt && ir_valid_q) begin
                        state_d    = HALT;
                        done_d     = 1'b1;
                        ir_valid_d = 1'b0;
                    end else if (bus.stall) begin
                        state_d = RUN;
                    end else if (bus.br_take && ir_valid_q) begin
                        // The word fetched this cycle is on the wrong path: bubble it.
                        fetch_pc_d = ir_pc_q + bus.br_off;
                        ir_valid_d = 1'b0;
                    end else begin
                        ir_d       = bus.im_data;
                        ir_pc_d    = fetch_pc_q;
                        ir_valid_d = 1'b1;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end
                HALT: begin
                    ir_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.im_addr  = fetch_pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch using immediate assertions.
module tb_instr_fetch;

    import code_pack::*;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Instruction memory contents: address pattern scrambled so words differ from PCs.
    function automatic logic [IW-1:0] memWord(input logic [PC_W-1:0] a);
        return a[IW-1:0] ^ 9'h0A5;
    endfunction

    assign bus.im_data = memWord(bus.im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic stl, input logic bt,
                                 input logic [PC_W-1:0] off, input logic hl);
        bus.start   = st;
        bus.stall   = stl;
        bus.br_take = bt;
        bus.br_off  = off;
        bus.halt    = hl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [PC_W-1:0] addr, input logic [IW-1:0] irW,
                            input logic [PC_W-1:0] irPc, input logic valid, input logic dn);
        checkOutput({tag, ".im_addr"},  32'(bus.im_addr),  32'(addr));
        checkOutput({tag, ".ir"},       32'(bus.ir),       32'(irW));
        checkOutput({tag, ".ir_pc"},    32'(bus.ir_pc),    32'(irPc));
        checkOutput({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(valid));
        checkOutput({tag, ".done"},     32'(bus.done),     32'(dn));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkAll("reset", 10'd0, NOP_WORD, 10'd0, 1'b0, 1'b0);

        #12 rst_n = 1'b1;
        stepClk();
        stepClk();
        checkAll("idle_hold", 10'd0, NOP_WORD, 10'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // First edge after start falls only enters RUN; the fetch lands on the second.
        stepClk();
        checkAll("first_run", 10'd0, NOP_WORD, 10'd0, 1'b0, 1'b0);
        stepClk();
        checkAll("first_fetch", 10'd1, memWord(10'd0), 10'd0, 1'b1, 1'b0);
        for (int pc = 1; pc <= 5; pc++) begin
            stepClk();
            checkAll("seq_a", 10'(pc + 1), memWord(10'(pc)), 10'(pc), 1'b1, 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 10'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepClk();
            checkAll("stall", 10'd6, memWord(10'd5), 10'd5, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int pc = 6; pc <= 18; pc++) begin
            stepClk();
            checkAll("seq_b", 10'(pc + 1), memWord(10'(pc)), 10'(pc), 1'b1, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 10'd4, 1'b0);
        stepClk();
        checkAll("branch_bubble", 10'd22, memWord(10'd18), 10'd18, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int pc = 22; pc <= 39; pc++) begin
            stepClk();
            checkAll("seq_c", 10'(pc + 1), memWord(10'(pc)), 10'(pc), 1'b1, 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 10'd4, 1'b1);
        stepClk();
        checkAll("halt", 10'd40, memWord(10'd39), 10'd39, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd4, 1'b0);
        stepClk();
        checkAll("halt_hold", 10'd40, memWord(10'd39), 10'd39, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        stepClk();
        checkAll("restart", 10'd0, memWord(10'd39), 10'd39, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        stepClk();
        checkAll("restart_run", 10'd0, memWord(10'd39), 10'd39, 1'b0, 1'b0);
        stepClk();
        checkAll("restart_f0", 10'd1, memWord(10'd0), 10'd0, 1'b1, 1'b0);
        stepClk();
        checkAll("restart_f1", 10'd2, memWord(10'd1), 10'd1, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 10'h3FD, 1'b0);
        stepClk();
        checkAll("neg_branch", 10'd1022, memWord(10'd1), 10'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        stepClk();
        checkAll("wrap_1022", 10'd1023, memWord(10'd1022), 10'd1022, 1'b1, 1'b0);
        stepClk();
        checkAll("wrap_1023", 10'd0, memWord(10'd1023), 10'd1023, 1'b1, 1'b0);
        stepClk();
        checkAll("wrap_0", 10'd1, memWord(10'd0), 10'd0, 1'b1, 1'b0);

        #3 rst_n = 1'b0;
        #1;
        checkAll("async_reset", 10'd0, NOP_WORD, 10'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        stepClk();
        checkAll("post_reset_run", 10'd0, NOP_WORD, 10'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 1'b0);
        stepClk();
        checkAll("branch_ignored", 10'd1, memWord(10'd0), 10'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
